// File: rtl/latch_loader_16.sv
// Nibble-to-word packer driving a 16-bit capture latch.
// The word is settled on dout one cycle before the load strobe and held until the next word completes.
module latch_loader_16 #(
  parameter int LOAD_WIDTH = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  nib_in,
  input  logic        nib_valid,
  output logic        nib_ready,
  input  logic        flush,
  output logic [15:0] dout,
  output logic        load,
  output logic [7:0]  word_cnt,
  output logic        busy
);

  // state   | meaning
  // COLLECT | accepting nibbles into the shift register
  // SETUP   | dout settled, load still low
  // STROBE  | load high for LOAD_WIDTH cycles
  // GAP     | load low, one cycle before accepting again
  typedef enum logic [1:0] {COLLECT, SETUP, STROBE, GAP} state_t;

  localparam logic [3:0] TMR_INIT = 4'(LOAD_WIDTH - 1);

  state_t      state, state_nxt;
  logic [1:0]  nib_cnt;
  logic [11:0] shift_reg;
  logic [11:0] shift_nxt;
  logic [15:0] word_nxt;
  logic [3:0]  tmr;
  logic        accept;
  logic        word_done;
  logic        tmr_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (word_done) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (tmr_done) state_nxt = GAP;
      GAP:     state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    nib_ready = (state == COLLECT) && !rst;
    accept    = nib_ready && nib_valid;
    word_done = accept && !flush && (nib_cnt == 2'd3);
    tmr_done  = (tmr == 4'd0);
    busy      = (state != COLLECT) || (nib_cnt != 2'd0);
  end

  // The first nibble ends up at the word's high end when MSB_FIRST, low end otherwise.
  always_comb begin
    if (MSB_FIRST) begin
      shift_nxt = {shift_reg[7:0], nib_in};
      word_nxt  = {shift_reg, nib_in};
    end else begin
      shift_nxt = {nib_in, shift_reg[11:4]};
      word_nxt  = {nib_in, shift_reg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_cnt   <= 2'd0;
      shift_reg <= 12'd0;
      dout      <= 16'd0;
      load      <= 1'b0;
      tmr       <= 4'd0;
      word_cnt  <= 8'd0;
    end else begin
      case (state)
        COLLECT: begin
          if (flush) begin
            nib_cnt   <= 2'd0;
            shift_reg <= 12'd0;
          end else if (accept) begin
            nib_cnt <= nib_cnt + 2'd1;
            if (nib_cnt == 2'd3) begin
              dout      <= word_nxt;
              shift_reg <= 12'd0;
            end else begin
              shift_reg <= shift_nxt;
            end
          end
        end
        SETUP: begin
          load     <= 1'b1;
          tmr      <= TMR_INIT;
          word_cnt <= word_cnt + 8'd1;
        end
        STROBE: begin
          if (tmr_done) load <= 1'b0;
          else          tmr  <= tmr - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_loader_16.sv
// Directed bench for latch_loader_16: vector table plus flush, reset, streaming and strobe-width sequences.
module tb_latch_loader_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  nib;
  logic        valid;
  logic        flush;

  logic        ready_a, load_a, busy_a;
  logic [15:0] dout_a;
  logic [7:0]  wcnt_a;
  logic        ready_b, load_b, busy_b;
  logic [15:0] dout_b;
  logic [7:0]  wcnt_b;

  logic        valid_c;
  logic [3:0]  nib_c   [2];
  logic        ready_c [2];
  logic        load_c  [2];
  logic        busy_c  [2];
  logic [15:0] dout_c  [2];
  logic [7:0]  wcnt_c  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latch_loader_16 #(.LOAD_WIDTH(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .nib_in(nib), .nib_valid(valid), .nib_ready(ready_a),
    .flush(flush), .dout(dout_a), .load(load_a), .word_cnt(wcnt_a), .busy(busy_a));

  latch_loader_16 #(.LOAD_WIDTH(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .nib_in(nib), .nib_valid(valid), .nib_ready(ready_b),
    .flush(flush), .dout(dout_b), .load(load_b), .word_cnt(wcnt_b), .busy(busy_b));

  latch_loader_16 #(.LOAD_WIDTH(1), .MSB_FIRST(1'b1)) u_lw1 (
    .clk(clk), .rst(rst), .nib_in(nib_c[0]), .nib_valid(valid_c), .nib_ready(ready_c[0]),
    .flush(1'b0), .dout(dout_c[0]), .load(load_c[0]), .word_cnt(wcnt_c[0]), .busy(busy_c[0]));

  latch_loader_16 #(.LOAD_WIDTH(15), .MSB_FIRST(1'b1)) u_lw15 (
    .clk(clk), .rst(rst), .nib_in(nib_c[1]), .nib_valid(valid_c), .nib_ready(ready_c[1]),
    .flush(1'b0), .dout(dout_c[1]), .load(load_c[1]), .word_cnt(wcnt_c[1]), .busy(busy_c[1]));

  typedef struct {
    logic [15:0] w;
    logic [15:0] exp_msb;
    logic [15:0] exp_lsb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_a && n < 50) begin
      tick();
      n++;
    end
    if (!ready_a) chk("wait_ready_timeout", 32'(ready_a), 32'd1);
  endtask

  task automatic step(input logic [3:0] n, input logic fl);
    nib   = n;
    valid = 1'b1;
    flush = fl;
    tick();
    valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic feed(input logic [15:0] w);
    for (int i = 0; i < 4; i++) step(w[15-4*i -: 4], 1'b0);
  endtask

  initial begin
    automatic int rises;
    automatic int last;
    automatic int cyc;
    automatic logic prev_load;
    automatic logic [15:0] prev_dout;
    automatic int acc     [2];
    automatic int len     [2];
    automatic int rises_c [2];
    automatic int lws     [2];
    automatic logic p_ready [2];
    automatic logic p_load  [2];
    automatic logic [15:0] p_dout [2];
    automatic logic [15:0] exp_w;

    vecs[0] = '{16'hABCD, 16'hABCD, 16'hDCBA};
    vecs[1] = '{16'h1234, 16'h1234, 16'h4321};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{16'h0F1E, 16'h0F1E, 16'hE1F0};
    vecs[5] = '{16'h8001, 16'h8001, 16'h1008};
    lws[0] = 1;
    lws[1] = 15;

    rst = 1'b1; nib = 4'd0; valid = 1'b0; flush = 1'b0;
    valid_c = 1'b0; nib_c[0] = 4'd0; nib_c[1] = 4'd0;
    repeat (3) tick();
    chk("rst_dout", 32'(dout_a), 32'h0);
    chk("rst_load", 32'(load_a), 32'h0);
    chk("rst_wcnt", 32'(wcnt_a), 32'h0);
    chk("rst_ready", 32'(ready_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(ready_a), 32'h1);

    // Back-to-back words, LOAD_WIDTH=2, both nibble orders
    for (int v = 0; v < 6; v++) begin
      wait_ready();
      feed(vecs[v].w);
      chk("e0_dout_msb", 32'(dout_a), 32'(vecs[v].exp_msb));
      chk("e0_dout_lsb", 32'(dout_b), 32'(vecs[v].exp_lsb));
      chk("e0_load", 32'(load_a), 32'h0);
      chk("e0_ready", 32'(ready_a), 32'h0);
      chk("e0_busy", 32'(busy_a), 32'h1);
      tick();
      chk("e1_load", 32'(load_a), 32'h1);
      chk("e1_wcnt", 32'(wcnt_a), 32'(v + 1));
      chk("e1_ready", 32'(ready_a), 32'h0);
      chk("e1_dout", 32'(dout_a), 32'(vecs[v].exp_msb));
      tick();
      chk("e2_load", 32'(load_a), 32'h1);
      chk("e2_dout", 32'(dout_a), 32'(vecs[v].exp_msb));
      tick();
      chk("e3_load", 32'(load_a), 32'h0);
      chk("e3_ready", 32'(ready_a), 32'h0);
      chk("e3_dout", 32'(dout_a), 32'(vecs[v].exp_msb));
      tick();
      chk("e4_ready", 32'(ready_a), 32'h1);
      chk("e4_busy", 32'(busy_a), 32'h0);
      chk("e4_dout", 32'(dout_a), 32'(vecs[v].exp_msb));
    end

    // Flush colliding with a valid nibble
    prev_dout = vecs[5].exp_msb;
    step(4'h1, 1'b0);
    step(4'h2, 1'b0);
    chk("partial_busy", 32'(busy_a), 32'h1);
    step(4'h3, 1'b1);
    chk("flush_busy", 32'(busy_a), 32'h0);
    step(4'h4, 1'b0);
    step(4'h5, 1'b0);
    step(4'h6, 1'b0);
    chk("flush_dout_held", 32'(dout_a), 32'(prev_dout));
    chk("flush_load_low", 32'(load_a), 32'h0);
    step(4'h7, 1'b0);
    chk("flush_dout_msb", 32'(dout_a), 32'h4567);
    chk("flush_dout_lsb", 32'(dout_b), 32'h7654);
    rises = 0;
    prev_load = load_a;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_a && !prev_load) rises++;
      prev_load = load_a;
    end
    chk("flush_one_load", 32'(rises), 32'd1);
    chk("flush_wcnt", 32'(wcnt_a), 32'd7);

    // Reset asserted while load is high
    wait_ready();
    feed(16'h9C3E);
    tick();
    chk("pre_rst_load", 32'(load_a), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_load", 32'(load_a), 32'h0);
    chk("async_dout", 32'(dout_a), 32'h0);
    chk("async_wcnt", 32'(wcnt_a), 32'h0);
    chk("async_ready", 32'(ready_a), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(ready_a), 32'h1);
    feed(16'h5A69);
    chk("rel_dout", 32'(dout_a), 32'h5A69);
    tick();
    chk("rel_load", 32'(load_a), 32'h1);
    chk("rel_wcnt", 32'(wcnt_a), 32'h1);
    tick();
    chk("rel_load2", 32'(load_a), 32'h1);
    tick();
    chk("rel_load_fall", 32'(load_a), 32'h0);

    // 256 streamed words: spacing and wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("stream_start_wcnt", 32'(wcnt_a), 32'h0);
    valid = 1'b1;
    rises = 0; last = 0; cyc = 0;
    prev_load = load_a;
    while (rises < 256 && cyc < 3000) begin
      tick();
      cyc++;
      nib = nib + 4'd1;
      if (load_a && !prev_load) begin
        if (rises > 0) chk("rise_spacing", 32'(cyc - last), 32'd8);
        last = cyc;
        rises++;
        if (rises == 255) chk("wcnt_255", 32'(wcnt_a), 32'd255);
      end
      prev_load = load_a;
    end
    valid = 1'b0;
    chk("stream_rises", 32'(rises), 32'd256);
    chk("stream_wrap", 32'(wcnt_a), 32'd0);

    // LOAD_WIDTH=1 and 15 with nib_valid held high
    for (int i = 0; i < 2; i++) begin
      acc[i] = 0; len[i] = 0; rises_c[i] = 0;
      nib_c[i] = 4'd0;
      p_ready[i] = ready_c[i];
      p_load[i] = load_c[i];
      p_dout[i] = dout_c[i];
    end
    valid_c = 1'b1;
    for (int c = 0; c < 250; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (p_ready[i]) acc[i]++;
        nib_c[i] = 4'(acc[i]);
        if (dout_c[i] !== p_dout[i]) begin
          chk("lw_dout_change_in_collect", 32'(p_ready[i]), 32'h1);
          exp_w = {4'(acc[i] - 4), 4'(acc[i] - 3), 4'(acc[i] - 2), 4'(acc[i] - 1)};
          chk("lw_dout_word", 32'(dout_c[i]), 32'(exp_w));
        end
        if (load_c[i] && !p_load[i]) begin
          rises_c[i]++;
          len[i] = 1;
          chk("lw_dout_settled", 32'(dout_c[i]), 32'(p_dout[i]));
        end else if (load_c[i]) begin
          len[i]++;
        end
        if (!load_c[i] && p_load[i]) chk("lw_load_width", 32'(len[i]), 32'(lws[i]));
        p_ready[i] = ready_c[i];
        p_load[i] = load_c[i];
        p_dout[i] = dout_c[i];
      end
    end
    valid_c = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("lw_enough_words", 32'(rises_c[i] >= 5), 32'h1);
      chk("lw_wcnt", 32'(wcnt_c[i]), 32'(rises_c[i] % 256));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
